// File: rtl/imem_loader.sv
// Byte-stream program loader and instruction memory for the Mips32 core.
// Optional build macro IMEM_CHECKSUM_EN adds a 4-byte trailer check before release.
module imem_loader #(
  parameter int          ADDR_SIZE  = 7,
  parameter logic [31:0] BREAK_WORD = 32'h0000000D
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [31:0]          raddr,
  output logic [31:0]          instr,
  output logic                 core_reset,
  input  logic                 halted,
  output logic [1:0]           state,
  output logic [ADDR_SIZE:0]   word_count,
  output logic [31:0]          cycle_count,
  output logic                 done,
  output logic                 error
);

  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] FULL = {1'b1, {ADDR_SIZE{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               st_q, st_d;
  logic [1:0]           lane_q, lane_d;
  logic [31:0]          asm_q, asm_d;
  logic [ADDR_SIZE:0]   wc_q, wc_d;
  logic [31:0]          cc_q, cc_d;
  logic                 err_q, err_d;
  logic                 accept;
  logic [31:0]          merged;
  logic                 we;
  logic [ADDR_SIZE-1:0] waddr;
  logic [31:0]          mem [DEPTH];

`ifdef IMEM_CHECKSUM_EN
  logic        chk_q, chk_d;
  logic [31:0] sum_q, sum_d;
  logic        fail_q, fail_d;
`endif

  // Ready depends only on state, so nothing combinational runs from in_valid to in_ready.
  assign in_ready = (st_q == S_IDLE) || (st_q == S_LOAD);
  assign accept   = in_valid & in_ready;
  // Upper lanes of asm_q are always zero, which gives the zero padding for free.
  assign merged   = asm_q | ({24'b0, in_data} << {lane_q, 3'b000});
  assign waddr    = wc_q[ADDR_SIZE-1:0];

  always_comb begin
    st_d       = st_q;
    lane_d     = lane_q;
    asm_d      = asm_q;
    wc_d       = wc_q;
    cc_d       = cc_q;
    err_d      = err_q;
    we         = 1'b0;
    done       = (st_q == S_DONE);
    core_reset = (st_q == S_IDLE) || (st_q == S_LOAD);
`ifdef IMEM_CHECKSUM_EN
    chk_d      = chk_q;
    sum_d      = sum_q;
    fail_d     = fail_q;
    core_reset = core_reset | fail_q;
`endif
    case (st_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          st_d = S_LOAD;
`ifdef IMEM_CHECKSUM_EN
          if (chk_q) begin
            // Trailer bytes only assemble the expected sum; they never reach memory.
            asm_d  = merged;
            lane_d = lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              lane_d = 2'd0;
              asm_d  = '0;
              chk_d  = 1'b0;
              if (merged == sum_q) begin
                st_d = S_RUN;
              end else begin
                err_d  = 1'b1;
                fail_d = 1'b1;
                st_d   = S_DONE;
              end
            end
          end else begin
`else
          begin
`endif
            if (wc_q == FULL) begin
              err_d = 1'b1;
            end else if ((lane_q == 2'd3) || in_last) begin
              we     = 1'b1;
              wc_d   = wc_q + 1'b1;
              lane_d = 2'd0;
              asm_d  = '0;
`ifdef IMEM_CHECKSUM_EN
              sum_d  = sum_q + merged;
`endif
            end else begin
              asm_d  = merged;
              lane_d = lane_q + 2'd1;
            end
            if (in_last) begin
`ifdef IMEM_CHECKSUM_EN
              chk_d = 1'b1;
`else
              st_d  = S_RUN;
`endif
            end
          end
        end
      end
      S_RUN: begin
        if (halted) begin
          st_d = S_DONE;
        end else if (cc_q != '1) begin
          cc_d = cc_q + 32'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q   <= S_IDLE;
      lane_q <= 2'd0;
      asm_q  <= '0;
      wc_q   <= '0;
      cc_q   <= '0;
      err_q  <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      chk_q  <= 1'b0;
      sum_q  <= '0;
      fail_q <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      lane_q <= lane_d;
      asm_q  <= asm_d;
      wc_q   <= wc_d;
      cc_q   <= cc_d;
      err_q  <= err_d;
`ifdef IMEM_CHECKSUM_EN
      chk_q  <= chk_d;
      sum_q  <= sum_d;
      fail_q <= fail_d;
`endif
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= merged;
  end

  always_comb begin
    instr = '0;
    if ((st_q == S_RUN) || (st_q == S_DONE)) begin
      if (raddr < 32'(DEPTH)) instr = mem[raddr[ADDR_SIZE-1:0]];
      else                    instr = BREAK_WORD;
    end
  end

  assign state       = st_q;
  assign word_count  = wc_q;
  assign cycle_count = cc_q;
  assign error       = err_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Front-end stage that feeds the Mips32 core's instruction port.
- Receives a program as a byte stream over a valid/ready handshake and packs the bytes into 32-bit words in an internal instruction memory.
- Holds the core in reset while loading, releases it to run, then serves instruction reads and counts cycles until the core reports halted.

Parameters:
ADDR_SIZE, 7, log2 of instruction memory depth in 32-bit words (DEPTH = 2**ADDR_SIZE)
BREAK_WORD, 32'h0000000D, word returned for any read at or beyond DEPTH

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
in_data  input  8  program byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts byte; transfer occurs when in_valid & in_ready at posedge
in_last  input  1  qualifies the final byte of the program
raddr  input  32  word address from the core (core's pc >> 2)
instr  output  32  instruction to the core
core_reset  output  1  reset to the core
halted  input  1  core halted flag
state  output  2  0=IDLE, 1=LOAD, 2=RUN, 3=DONE
word_count  output  ADDR_SIZE+1  number of words written
cycle_count  output  32  RUN cycles with halted==0
done  output  1  high in DONE
error  output  1  sticky overflow/check error

Behaviour:
- Reset values:
  - state=IDLE, core_reset=1, in_ready=1, word_count=0, cycle_count=0, done=0, error=0.
  - Byte lane pointer = 0, assembly register = 0.
  - Memory contents are not cleared.
- Reset mid-operation returns to the reset values on the next edge, regardless of state.
- IDLE→LOAD on the first accepted byte. That byte is processed as in LOAD.
- Packing is little-endian: byte k of a word goes to bits [8k+7:8k].
- On the 4th byte of a word:
  - The word is written at mem[word_count] on the same edge.
  - word_count increments and the lane pointer wraps to 0.
- in_last on an accepted byte terminates the program:
  - A partial word is zero-padded in its upper bytes and written on the same edge; word_count increments.
  - in_last on lane 3 writes once only.
  - in_ready drops the next cycle. state goes to RUN, or to the check phase if IMEM_CHECKSUM_EN is defined.
- Overflow: a byte accepted when word_count==DEPTH is discarded and error is set. Loading continues until in_last.
- in_ready:
  - 1 in IDLE and LOAD.
  - 0 in RUN and DONE.
  - Independent of in_valid, so there is no combinational path.
- RUN:
  - core_reset=0 from the first RUN cycle.
  - cycle_count increments each cycle halted==0, saturating at 32'hFFFFFFFF.
  - halted==1 at a posedge → DONE next cycle. cycle_count freezes on that edge.
- DONE: done=1, core_reset=0, holds until reset.
- instr is combinational:
  - raddr < DEPTH → mem[raddr[ADDR_SIZE-1:0]].
  - raddr >= DEPTH → BREAK_WORD, so a runaway core halts.
  - In IDLE/LOAD, instr=0.
- A write and a read of the same address in the same cycle is not possible, because reads occur only in RUN/DONE.

Optional Feature:
- Macro: IMEM_CHECKSUM_EN.
- Defined:
  - After the in_last byte, the loader stays in LOAD (state=1) with in_ready=1.
  - It accepts exactly 4 further trailer bytes, little-endian, forming a 32-bit value.
  - in_last on trailer bytes is ignored.
  - The trailer is compared with the mod-2^32 sum of all written words, including padded partials and excluding discarded overflow bytes.
  - Match → RUN.
  - Mismatch → error=1 and DONE with core_reset held at 1 and done=1.
  - Trailer bytes are never written to memory.
- Not defined: in_last ends loading directly and no sum logic exists.

Test Plan:
1. Reset, stream 8 bytes 13 00 00 00 / 00 00 00 00 with in_last on byte 8 → mem[0]=0x00000013, mem[1]=0, word_count=2; RUN next cycle with core_reset=0; raddr=0 gives instr=0x00000013.
2. 6 bytes AA BB CC DD 11 22 with in_last on byte 6 → mem[0]=0xDDCCBBAA, mem[1]=0x00002211, word_count=2.
3. After load, drive halted=0 for 10 cycles then 1 → cycle_count=10, state=DONE, done=1, in_ready=0; raddr=DEPTH gives instr=0x0000000D.
4. ADDR_SIZE=2, stream 5 full words (20 bytes) → word_count=4, error=1, mem[0..3] = first 4 words; RUN still entered after in_last.
5. Assert reset after 3 bytes of a word → state=IDLE, word_count=0, lane=0; restarting with 4 bytes writes mem[0] correctly.
6. IMEM_CHECKSUM_EN: words 1, 2 plus trailer 03 00 00 00 → RUN. Trailer 04 00 00 00 → error=1, DONE, core_reset=1.
